// File: rtl/systolic_tile.sv
// rtl/systolic_tile.sv - N x N weight-stationary systolic matrix-multiply tile with skew, de-skew and sequencer
module systolic_tile #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = 16,
  parameter int MW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [MW-1:0]   m_len,
  output logic            busy,
  output logic            done,
  input  logic            w_valid,
  input  logic [N*DW-1:0] w_data,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [N*DW-1:0] a_data,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [N*AW-1:0] r_data
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FIN} state_t;

  state_t state, state_nx;

  logic [CW-1:0] w_cnt;
  logic [MW-1:0] m_reg;
  logic [MW-1:0] row_cnt;
  logic [MW-1:0] res_cnt;

  logic stall, adv, a_hs, r_hs, clr;

  logic signed [DW-1:0]   w_reg  [N][N];
  logic signed [DW-1:0]   act    [N][N];
  logic signed [AW-1:0]   psum   [N][N];
  logic signed [DW-1:0]   act_in [N][N];
  logic signed [AW-1:0]   ps_in  [N][N];
  logic signed [2*DW-1:0] prod   [N][N];
  logic signed [DW-1:0]   row_in [N];
  logic signed [AW-1:0]   col_out[N];
  logic [2*N-1:0]         tag;

  // A pending result that is not taken freezes every pipeline stage together.
  assign stall = r_valid && !r_ready;
  assign adv   = ((state == STREAM) || (state == DRAIN)) && !stall;
  assign a_hs  = a_valid && a_ready;
  assign r_hs  = r_valid && r_ready;
  // Datapath is wiped while new weights load so no stale partial sums leak into the next job.
  assign clr   = (state == LOAD_W);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = LOAD_W;
      LOAD_W: if (w_valid && (w_cnt == CW'(N - 1))) state_nx = (m_reg == '0) ? FIN : STREAM;
      STREAM: if (a_hs && ((row_cnt + MW'(1)) == m_reg)) state_nx = DRAIN;
      DRAIN:  if (r_hs && ((res_cnt + MW'(1)) == m_reg)) state_nx = FIN;
      FIN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; a_ready also sees r_ready through stall.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == FIN);
    a_ready = (state == STREAM) && !stall;
  end

  // Job length, weight-row, accepted-row and result counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_reg   <= '0;
      w_cnt   <= '0;
      row_cnt <= '0;
      res_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      m_reg   <= m_len;
      w_cnt   <= '0;
      row_cnt <= '0;
      res_cnt <= '0;
    end else begin
      if ((state == LOAD_W) && w_valid) w_cnt <= w_cnt + CW'(1);
      if (a_hs) row_cnt <= row_cnt + MW'(1);
      if (r_hs) res_cnt <= res_cnt + MW'(1);
    end
  end

  // Weight rows are written in arrival order while loading.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          w_reg[r][j] <= '0;
    end else if ((state == LOAD_W) && w_valid) begin
      for (int j = 0; j < N; j++)
        w_reg[w_cnt][j] <= w_data[j*DW +: DW];
    end
  end

  genvar gr, gj;

  // Input skew: lane r is delayed r+1 advances so it meets its partial sum on the diagonal.
  for (gr = 0; gr < N; gr++) begin : g_skew
    localparam int S = gr + 1;
    logic signed [DW-1:0] sk [S];
    // Shift the lane one stage per advance; bubbles inject zero.
    always_ff @(posedge clk) begin
      if (reset || clr) begin
        for (int d = 0; d < S; d++) sk[d] <= '0;
      end else if (adv) begin
        sk[0] <= a_hs ? a_data[gr*DW +: DW] : '0;
        for (int d = 1; d < S; d++) sk[d] <= sk[d-1];
      end
    end
    assign row_in[gr] = sk[S-1];
  end

  // PE interconnect: activations flow right, partial sums flow down.
  for (gr = 0; gr < N; gr++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_left
        assign act_in[gr][gj] = row_in[gr];
      end else begin : g_mid
        assign act_in[gr][gj] = act[gr][gj-1];
      end
      if (gr == 0) begin : g_top
        assign ps_in[gr][gj] = '0;
      end else begin : g_below
        assign ps_in[gr][gj] = psum[gr-1][gj];
      end
      assign prod[gr][gj] = (2*DW)'(act_in[gr][gj]) * (2*DW)'(w_reg[gr][gj]);
    end
  end

  // PE registers: each advance latches the passing activation and accumulates into the sum.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++) begin
          act[r][j]  <= '0;
          psum[r][j] <= '0;
        end
    end else if (adv) begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++) begin
          act[r][j]  <= act_in[r][j];
          psum[r][j] <= ps_in[r][j] + AW'(prod[r][j]);
        end
    end
  end

  // Output de-skew: column j waits N-1-j advances so all lanes of a row line up.
  for (gj = 0; gj < N; gj++) begin : g_deskew
    localparam int D = N - 1 - gj;
    if (D == 0) begin : g_pass
      assign col_out[gj] = psum[N-1][gj];
    end else begin : g_dly
      logic signed [AW-1:0] ds [D];
      // Delay line for this column, frozen with the array.
      always_ff @(posedge clk) begin
        if (reset || clr) begin
          for (int d = 0; d < D; d++) ds[d] <= '0;
        end else if (adv) begin
          ds[0] <= psum[N-1][gj];
          for (int d = 1; d < D; d++) ds[d] <= ds[d-1];
        end
      end
      assign col_out[gj] = ds[D-1];
    end
  end

  // Valid tag travels alongside each injected row so bubbles never surface as results.
  always_ff @(posedge clk) begin
    if (reset || clr) tag <= '0;
    else if (adv)     tag <= {tag[2*N-2:0], a_hs};
  end

  // Result register only moves on an advance, so data holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (adv) begin
      r_valid <= tag[2*N-1];
      for (int j = 0; j < N; j++) r_data[j*AW +: AW] <= col_out[j];
    end
  end

endmodule

// File: tb/tb_systolic_tile.sv
// tb/tb_systolic_tile.sv - directed self-checking bench for systolic_tile
module tb_systolic_tile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  m_len = '0;
  logic        busy, done;
  logic        w_valid = 1'b0;
  logic [15:0] w_data = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [15:0] a_data = '0;
  logic        r_valid;
  logic        r_ready = 1'b1;
  logic [31:0] r_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] a_rows [8];
  logic [31:0] e_rows [8];
  logic [31:0] rq [$];

  systolic_tile #(.N(2), .DW(8), .AW(16), .MW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .m_len(m_len),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (r_valid && r_ready) rq.push_back(r_data);

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  function automatic logic [15:0] arow(input int a0, input int a1);
    logic [7:0] x0, x1;
    x0 = a0[7:0];
    x1 = a1[7:0];
    return {x1, x0};
  endfunction

  function automatic logic [31:0] crow(input int c0, input int c1);
    logic [15:0] y0, y1;
    y0 = c0[15:0];
    y1 = c1[15:0];
    return {y1, y0};
  endfunction

  function automatic logic [31:0] exp_at(input int i);
    if (i < 8) return e_rows[i];
    return '1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input int m, input logic [15:0] w0, input logic [15:0] w1);
    start = 1'b1;
    m_len = m[7:0];
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    w_valid = 1'b1;
    w_data  = w0;
    step();
    w_data  = w1;
    step();
    w_valid = 1'b0;
  endtask

  task automatic stream(input int nrows, input int gap, input int v_lo, input int v_hi,
                        input int r_lo, input int r_hi);
    int sent;
    int c;
    bit fin;
    bit hs;
    sent = 0;
    c = 0;
    fin = 1'b0;
    while (!fin && c < 400) begin
      a_valid = (sent < nrows) && (c >= sent * (gap + 1)) && !(c >= v_lo && c <= v_hi);
      a_data  = (sent < nrows) ? a_rows[sent] : '0;
      r_ready = !(c >= r_lo && c <= r_hi);
      #1;
      check("busy_during", busy, 1);
      if (done) begin
        fin = 1'b1;
      end else begin
        if (r_valid && !r_ready) begin
          check("stall_a_ready", a_ready, 0);
          check("stall_hold", r_data, exp_at(rq.size()));
        end
        hs = a_valid && a_ready;
        step();
        if (hs) sent++;
        c++;
      end
    end
    a_valid = 1'b0;
    r_ready = 1'b1;
    check("done_seen", fin, 1);
    check("rows_sent", sent, nrows);
    step();
    check("busy_after_done", busy, 0);
    check("done_pulse_end", done, 0);
    check("r_valid_idle", r_valid, 0);
    check("result_count", rq.size(), nrows);
    for (int i = 0; i < nrows; i++)
      check("result_row", (i < rq.size()) ? rq[i] : 32'hxxxx_xxxx, e_rows[i]);
    rq.delete();
  endtask

  initial begin
    int dseen;

    // Reset state
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_data", r_data, 0);
    reset = 1'b0;
    step();

    // 1: identity weights, exact latency
    begin_job(2, arow(1, 0), arow(0, 1));
    r_ready = 1'b1;
    a_valid = 1'b1;
    a_data  = arow(1, 2);
    #1;
    check("t1_a_ready", a_ready, 1);
    step();
    a_data = arow(3, 4);
    step();
    a_valid = 1'b0;
    step();
    step();
    check("t1_lat_early", r_valid, 0);
    step();
    check("t1_lat_valid", r_valid, 1);
    check("t1_row0", r_data, crow(1, 2));
    step();
    check("t1_row1_valid", r_valid, 1);
    check("t1_row1", r_data, crow(3, 4));
    check("t1_no_done_yet", done, 0);
    step();
    check("t1_done", done, 1);
    check("t1_busy_in_done", busy, 1);
    check("t1_r_valid_clear", r_valid, 0);
    step();
    check("t1_done_low", done, 0);
    check("t1_busy_low", busy, 0);
    check("t1_count", rq.size(), 2);
    rq.delete();

    // 2: general weights, start pulse while busy ignored
    a_rows[0] = arow(5, 6);  e_rows[0] = crow(23, 34);
    a_rows[1] = arow(7, 8);  e_rows[1] = crow(31, 46);
    begin_job(2, arow(1, 2), arow(3, 4));
    start = 1'b1;
    m_len = 8'd7;
    step();
    start = 1'b0;
    stream(2, 0, -1, -1, -1, -1);

    // 3a: wrap at the negative extreme
    a_rows[0] = arow(-128, -128);  e_rows[0] = crow(-32768, -32768);
    begin_job(1, arow(-128, -128), arow(-128, -128));
    stream(1, 0, -1, -1, -1, -1);

    // 3b: largest positive product sum
    a_rows[0] = arow(127, 127);  e_rows[0] = crow(32258, 32258);
    begin_job(1, arow(127, 127), arow(127, 127));
    stream(1, 0, -1, -1, -1, -1);

    // 4: backpressure for 5 cycles while rows are still pending
    a_rows[0] = arow(1, 0);   e_rows[0] = crow(1, 2);
    a_rows[1] = arow(0, 1);   e_rows[1] = crow(3, 4);
    a_rows[2] = arow(1, 1);   e_rows[2] = crow(4, 6);
    a_rows[3] = arow(2, -1);  e_rows[3] = crow(-1, 0);
    begin_job(4, arow(1, 2), arow(3, 4));
    stream(4, 0, 2, 4, 5, 9);

    // 5: bubbles between rows
    a_rows[0] = arow(1, 2);  e_rows[0] = crow(7, 10);
    a_rows[1] = arow(3, 4);  e_rows[1] = crow(15, 22);
    a_rows[2] = arow(5, 6);  e_rows[2] = crow(23, 34);
    begin_job(3, arow(1, 2), arow(3, 4));
    stream(3, 2, -1, -1, -1, -1);

    // 6: reset mid-stream aborts without done
    begin_job(3, arow(1, 0), arow(0, 1));
    a_valid = 1'b1;
    a_data  = arow(9, 9);
    step();
    a_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_a_ready", a_ready, 0);
    check("t6_rst_r_valid", r_valid, 0);
    check("t6_rst_r_data", r_data, 0);
    reset = 1'b0;
    dseen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || r_valid || busy) dseen++;
    end
    check("t6_quiet_after_rst", dseen, 0);
    rq.delete();

    // 6: m_len=0 job, second start during load ignored
    start = 1'b1;
    m_len = 8'd0;
    step();
    start = 1'b0;
    w_valid = 1'b1;
    w_data  = arow(3, 3);
    step();
    start = 1'b1;
    m_len = 8'd1;
    step();
    start = 1'b0;
    w_valid = 1'b0;
    check("t6_m0_done", done, 1);
    check("t6_m0_busy", busy, 1);
    check("t6_m0_r_valid", r_valid, 0);
    step();
    check("t6_m0_done_low", done, 0);
    check("t6_m0_busy_low", busy, 0);
    step();
    check("t6_start_ignored", busy, 0);
    check("t6_no_results", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_tile.md
Name: systolic_tile

Overview:
Parametrised N×N weight-stationary systolic matrix-multiply tile. It computes C = A×W, where W is an N×N matrix preloaded once and A is a stream of M rows with M set at run time. The tile contains its own input skew, output de-skew and sequencing FSM. Activation rows come in, and result rows go out, over valid/ready handshakes with full backpressure. It is the generalised successor of the fixed 2×2 MMU/accumulator path and sits between the unified buffer and the weight memory.

Parameters:
N, 2, array dimension (rows = columns = lanes)
DW, 8, signed width of activations and weights
AW, 16, signed width of accumulators/results
MW, 8, width of the run-time row-count input

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a job when IDLE
m_len  in  MW  number of A rows; sampled on accepted start
busy  out  1  high from cycle after accepted start through done cycle
done  out  1  one-cycle pulse at job end
w_valid  in  1  weight row beat (accepted every cycle in LOAD_W)
w_data  in  N*DW  weight row r; lane j = W[r][j] at bits [j*DW +: DW]
a_valid  in  1  activation row valid
a_ready  out  1  activation row accepted when a_valid && a_ready
a_data  in  N*DW  A row; lane r = A[i][r]
r_valid  out  1  result row valid
r_ready  in  1  result consumer ready
r_data  out  N*AW  result row; lane j = C[i][j] at bits [j*AW +: AW]

Behaviour:
- Reset (synchronous, clk edge with reset=1): FSM→IDLE; busy, done, a_ready, r_valid = 0; r_data = 0; weight regs, skew regs, PE partial sums and row counters cleared. Reset mid-job aborts the job with no done.
- FSM: IDLE →(start) LOAD_W →(N-th w_valid beat) STREAM →(M-th row accepted) DRAIN →(last result handshake) FIN →(1 cycle, done=1) IDLE.
- m_len=0: LOAD_W → FIN directly after N weight beats; no r_valid.
- start while not IDLE: ignored. w_valid outside LOAD_W: ignored. Weight rows load in order 0..N-1, with no ready signal.
- Stall: stall = r_valid && !r_ready. The whole array, skew and de-skew freeze while stall=1.
- a_ready = (state==STREAM) && !stall. This path is combinational from r_ready.
- Advance: every non-stalled cycle in STREAM/DRAIN, the array steps. In STREAM with no handshake, a zero bubble is injected, tagged invalid.
- Each injected row carries a valid tag through a 2N-stage tag pipeline. The result for a row accepted on advance k is registered into r_data with r_valid=1 on advance k+2N. Minimum latency is 2N cycles from a handshake to r_valid. Bubbles never produce r_valid.
- The r_data/r_valid register updates only on non-stalled cycles. When a stalled advance produces an invalid tag, r_valid clears once the pending row is handshaken. Data is held stable while r_valid && !r_ready.
- Result order equals input order. No row is lost or duplicated under any a_valid/r_ready pattern.
- Arithmetic: DW×DW signed products are sign-extended to AW. Sums wrap modulo 2^AW in two's complement, with no saturation.
- The row counter counts accepted rows up to m_len. The result counter counts result handshakes. DRAIN exits when the result count equals m_len.
- done is asserted in the cycle after the final result handshake. busy is high in that same done cycle and drops the following cycle.

Test Plan:
1. N=2, W=identity, m_len=2, A=[1,2],[3,4], r_ready=1 → r_data [1,2] then [3,4]; first r_valid exactly 4 cycles after first a handshake; done 1 cycle after last result.
2. W=[[1,2],[3,4]], A=[[5,6],[7,8]] → [23,34],[31,46] in order; busy high throughout, low after done.
3. Wrap: all W=-128, A row [-128,-128] → each lane 32768 wraps to 0x8000 (-32768). A row [127,127] with W=127 → 32258.
4. Backpressure: m_len=4, r_ready low for 5 cycles mid-stream → r_data stable while held, a_ready=0 while stalled, all 4 results correct and in order.
5. Bubbles: a_valid toggling 1,0,0,1,… over 3 rows → exactly 3 r_valid handshakes, correct values, no spurious r_valid.
6. Reset asserted mid-STREAM → next cycle all outputs 0 and no done. Then start with m_len=0 plus 2 weight beats → done 1 cycle after the FIN entry, never r_valid. A start pulse while busy is ignored.
